mc_cpu_core: RTL and testbench
==============================

MC_CPU_CORE -- requirements
Module: mc_cpu_core

Interface
REQ-001 Parameter DATA_W, default 16: data and instruction word width.
REQ-002 Parameter ADDR_W, default 5: PC and memory address width.
REQ-003 Parameter OPC_W, default 5: opcode field width.
REQ-004 Parameter NREG, default 4: register-file depth, power of 2; REG_W = clog2(NREG).
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 read_data  in  DATA_W  memory read data, valid when mem_ready=1.
REQ-008 mem_ready  in  1  memory accepts or completes the current request.
REQ-009 mem_req  out  1  memory request.
REQ-010 mem_we  out  1  1 = write, 0 = read.
REQ-011 mem_addr  out  ADDR_W  request address.
REQ-012 mem_wdata  out  DATA_W  write data.
REQ-013 PC_out  out  ADDR_W  current PC.
REQ-014 opcode_out  out  OPC_W  opcode of the instruction in the IR.
REQ-015 zero_flag  out  1  last ALU result was zero.
REQ-016 carry_flag  out  1  carry or borrow out of the last ADD or SUB.
REQ-017 done  out  1  core halted.
REQ-018 illegal_op  out  1  illegal opcode trapped; see Configuration.

Function
REQ-019 Instruction layout from MSB down: opcode[OPC_W], rd[REG_W], zero pad, operand[ADDR_W] in the LSBs. rs = operand[REG_W-1:0]. Elaboration fails unless DATA_W >= OPC_W+REG_W+ADDR_W.
REQ-020 Opcodes:
- NOP=0
- LDI=1: rd <= zero-extended operand
- LD=2: rd <= mem[operand]
- ST=3: mem[operand] <= rd
- ADD=4, SUB=5, AND=6, OR=7: rd <= rd op rs
- JMP=8: PC <= operand
- JZ=9: if rd==0, PC <= operand
- HALT = all ones
- All other codes are illegal.
REQ-021 FSM states are FETCH, DECODE, EXECUTE, MEM, HALT; the reset state is FETCH.
REQ-022 FETCH
- Drive mem_req=1, mem_we=0, mem_addr=PC.
- When mem_ready=1: IR <= read_data, PC <= PC+1 modulo 2^ADDR_W, go to DECODE.
REQ-023 DECODE: opcode_out and register operands update; always go to EXECUTE.
REQ-024 EXECUTE
- ALU ops, LDI, NOP, JMP, JZ: commit results, go to FETCH.
- LD, ST: go to MEM.
- HALT: go to HALT.
REQ-025 MEM
- Drive mem_req=1, mem_addr=operand, mem_we=1 for ST, mem_wdata=rd.
- When mem_ready=1: LD writes read_data into rd; go to FETCH.
REQ-026 Handshake: while mem_req=1 and mem_ready=0, mem_req, mem_we, mem_addr and mem_wdata stay stable; wait states are unbounded. mem_req=0 in DECODE, EXECUTE and HALT.
REQ-027 Latency with zero-wait memory: 3 cycles per instruction, 4 for LD and ST.
REQ-028 ADD and SUB are DATA_W wide with carry or borrow into carry_flag. AND and OR clear carry_flag. zero_flag updates on all ALU ops only.
REQ-029 JMP to an address at or above 2^ADDR_W cannot occur because the operand is ADDR_W wide. PC increment from all ones wraps to 0.
REQ-030 HALT state is absorbing: done=1, mem_req=0, and only reset_n exits it.
REQ-031 rd==rs is legal and reads the old value.

Reset
REQ-032 Asserting reset_n=0 immediately forces all outputs to 0: mem_req, mem_we, mem_addr, mem_wdata, PC_out, opcode_out, flags, done, illegal_op.
REQ-033 Reset also clears the register file and IR, and sets state to FETCH.
REQ-034 Reset asserted mid-transaction drops mem_req asynchronously; no register write occurs.
REQ-035 After reset_n deasserts, the first rising edge finds the core in FETCH with mem_req=1 and mem_addr=0.

Configuration
REQ-036 Macro MC_CPU_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in EXECUTE enters HALT with illegal_op=1 and done=1.
- Undefined: an illegal opcode executes as NOP and illegal_op is tied to 0.

Structure
REQ-037 Package mc_cpu_pkg holds the opcode enum, the FSM state enum and field-position helper constants.
REQ-038 The ALU is sub-module mc_cpu_alu: combinational, DATA_W parameter, outputs result, carry, zero.

Verification
REQ-039 Zero-wait program LDI r1,5; LDI r2,3; ADD r1,r2; HALT -> r1=8, zero_flag=0, carry_flag=0, done=1 at cycle 12 after reset release.
REQ-040 LDI r1,0; SUB r1,r2 with r2=1 -> r1=0xFFFF, carry_flag=1, zero_flag=0.
REQ-041 LD r0,[20] with mem_ready held low 3 cycles -> mem_addr=20 stable for 4 cycles, then r0=read_data; ST r0,[21] -> mem_we=1, mem_wdata=r0.
REQ-042 JZ r3,0 at PC=31 with r3=0 -> PC=0. Fetch at PC=31 without a jump -> PC wraps to 0.
REQ-043 Opcode 12 -> with MC_CPU_ILLEGAL_TRAP_EN: illegal_op=1, done=1. Without the macro: treated as NOP, next fetch proceeds.
REQ-044 reset_n pulsed low during MEM wait -> mem_req=0 immediately, registers=0, then refetch from address 0.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the mc_cpu multi-cycle core: FSM states, opcodes, ALU selects
// and instruction field position helpers.
package mc_cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    // OP_ILLEGAL is an internal class covering every undefined code, not a fetched encoding.
    typedef enum logic [4:0] {
        OP_NOP     = 5'd0,
        OP_LDI     = 5'd1,
        OP_LD      = 5'd2,
        OP_ST      = 5'd3,
        OP_ADD     = 5'd4,
        OP_SUB     = 5'd5,
        OP_AND     = 5'd6,
        OP_OR      = 5'd7,
        OP_JMP     = 5'd8,
        OP_JZ      = 5'd9,
        OP_ILLEGAL = 5'd10,
        OP_HALT    = 5'd31
    } opc_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_t;

    localparam int unsigned NUM_DEFINED_OPS = 10;

    function automatic int opc_lsb(input int data_w, input int opc_w);
        return data_w - opc_w;
    endfunction

    function automatic int rd_lsb(input int data_w, input int opc_w, input int reg_w);
        return data_w - opc_w - reg_w;
    endfunction

endpackage

// File: rtl/mc_cpu_alu.sv
// Combinational ALU for mc_cpu_core: ADD/SUB with carry/borrow out, AND/OR with carry cleared.
module mc_cpu_alu
    import mc_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide_s;

    // Extra MSB of the widened result holds carry (ADD) or borrow (SUB).
    always_comb begin
        wide_s = '0;
        case (op)
            ALU_ADD: wide_s = {1'b0, a} + {1'b0, b};
            ALU_SUB: wide_s = {1'b0, a} - {1'b0, b};
            ALU_AND: wide_s = {1'b0, a & b};
            ALU_OR:  wide_s = {1'b0, a | b};
            default: wide_s = '0;
        endcase
        result = wide_s[DATA_W-1:0];
        carry  = wide_s[DATA_W];
        zero   = (wide_s[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/HALT core with a shared memory port.
// Optional macro MC_CPU_ILLEGAL_TRAP_EN: undefined opcodes halt with illegal_op=1 instead of acting as NOP.
module mc_cpu_core
    import mc_cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 5,
    parameter int NREG   = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] read_data,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] PC_out,
    output logic [OPC_W-1:0]  opcode_out,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              done,
    output logic              illegal_op
);

    localparam int REG_W   = $clog2(NREG);
    localparam int OPC_LSB = opc_lsb(DATA_W, OPC_W);
    localparam int RD_LSB  = rd_lsb(DATA_W, OPC_W, REG_W);

    if (DATA_W < OPC_W + REG_W + ADDR_W) begin : g_width_check
        $error("mc_cpu_core: DATA_W cannot hold opcode, rd and operand fields");
    end

    state_t             state_q;
    opc_t               opc_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic [DATA_W-1:0]  ir_q;
    logic [OPC_W-1:0]   opcode_q;
    logic [DATA_W-1:0]  op_a_q;
    logic [DATA_W-1:0]  op_b_q;
    logic               zero_q;
    logic               carry_q;
    logic [DATA_W-1:0]  rf_q [NREG];
`ifdef MC_CPU_ILLEGAL_TRAP_EN
    logic               illegal_q;
`endif

    logic [OPC_W-1:0]   ir_opc_s;
    logic [REG_W-1:0]   ir_rd_s;
    logic [REG_W-1:0]   ir_rs_s;
    logic [ADDR_W-1:0]  ir_operand_s;
    logic               unused_ir_s;
    logic [DATA_W-1:0]  alu_result_s;
    logic               alu_carry_s;
    logic               alu_zero_s;

    assign ir_opc_s     = ir_q[OPC_LSB +: OPC_W];
    assign ir_rd_s      = ir_q[RD_LSB +: REG_W];
    assign ir_rs_s      = ir_q[REG_W-1:0];
    assign ir_operand_s = ir_q[ADDR_W-1:0];
    assign unused_ir_s  = ^ir_q;
    assign pc_d         = pc_q + ADDR_W'(1);

    function automatic opc_t decode_op(input logic [OPC_W-1:0] f);
        opc_t o;
        if (f == {OPC_W{1'b1}}) begin
            o = OP_HALT;
        end else if (f < OPC_W'(NUM_DEFINED_OPS)) begin
            o = opc_t'(5'(f));
        end else begin
            o = OP_ILLEGAL;
        end
        return o;
    endfunction

    // ADD/SUB/AND/OR encodings share their low two bits with the ALU select.
    mc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (op_a_q),
        .b      (op_b_q),
        .op     (opc_q[1:0]),
        .result (alu_result_s),
        .carry  (alu_carry_s),
        .zero   (alu_zero_s)
    );

    // Main sequencer: state, PC, IR, decoded operands, flags and register file.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            opc_q    <= OP_NOP;
            pc_q     <= '0;
            ir_q     <= '0;
            opcode_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
`ifdef MC_CPU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= read_data;
                        pc_q    <= pc_d;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opc_q    <= decode_op(ir_opc_s);
                    opcode_q <= ir_opc_s;
                    op_a_q   <= rf_q[ir_rd_s];
                    op_b_q   <= rf_q[ir_rs_s];
                    state_q  <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    state_q <= S_FETCH;
                    case (opc_q)
                        OP_LDI: rf_q[ir_rd_s] <= DATA_W'(ir_operand_s);
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            rf_q[ir_rd_s] <= alu_result_s;
                            zero_q        <= alu_zero_s;
                            carry_q       <= alu_carry_s;
                        end
                        OP_JMP: pc_q <= ir_operand_s;
                        OP_JZ: begin
                            if (op_a_q == '0) begin
                                pc_q <= ir_operand_s;
                            end
                        end
                        OP_LD, OP_ST: state_q <= S_MEM;
                        OP_HALT:      state_q <= S_HALT;
`ifdef MC_CPU_ILLEGAL_TRAP_EN
                        OP_ILLEGAL: begin
                            illegal_q <= 1'b1;
                            state_q   <= S_HALT;
                        end
`endif
                        default: state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (opc_q == OP_LD) begin
                            rf_q[ir_rd_s] <= read_data;
                        end
                        state_q <= S_FETCH;
                    end
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // reset_n gates mem_req so the reset FETCH state never requests the bus while held.
    assign mem_req    = reset_n & ((state_q == S_FETCH) | (state_q == S_MEM));
    assign mem_we     = (state_q == S_MEM) & (opc_q == OP_ST);
    assign mem_addr   = (state_q == S_MEM) ? ir_operand_s : pc_q;
    assign mem_wdata  = (state_q == S_MEM) ? op_a_q : '0;
    assign PC_out     = pc_q;
    assign opcode_out = opcode_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
    assign done       = (state_q == S_HALT);
`ifdef MC_CPU_ILLEGAL_TRAP_EN
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed self-checking bench for mc_cpu_core with a zero/variable-wait memory model.
module tb_mc_cpu_core;

    localparam logic [4:0] NOP = 5'd0, LDI = 5'd1, LD = 5'd2, ST = 5'd3, ADD = 5'd4, SUB = 5'd5,
                           AND_ = 5'd6, OR_ = 5'd7, JMP = 5'd8, JZ = 5'd9, HALT = 5'd31;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] read_data;
    logic        mem_ready;
    logic        mem_req, mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [4:0]  pc_out;
    logic [4:0]  opcode_out;
    logic        zero_flag, carry_flag, done, illegal_op;

    logic [15:0] prog [32];
    logic [15:0] wmem [32];
    int          tests = 0;
    int          fails = 0;
    int          n;

    mc_cpu_core dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .read_data  (read_data),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .PC_out     (pc_out),
        .opcode_out (opcode_out),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .done       (done),
        .illegal_op (illegal_op)
    );

    always #5 clock = ~clock;

    assign read_data = prog[mem_addr];

    // Write log: 16'hDEAD marks a location the core never wrote since the last reset.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) wmem[i] <= 16'hDEAD;
        end else if (mem_req && mem_we && mem_ready) begin
            wmem[mem_addr] <= mem_wdata;
        end
    end

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [1:0] rd, input logic [4:0] opd);
        return {op, rd, 4'b0000, opd};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
    endtask

    task automatic start();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clock);
    endtask

    task automatic run_to_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (!done && cyc < max_cyc) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        clear_prog();
        prog[0] = enc(LDI, 2'd1, 5'd5);
        reset_n = 1'b0; mem_ready = 1'b1;
        @(negedge clock);
        tests++; if ({mem_req, mem_we, mem_addr, mem_wdata, pc_out, opcode_out, zero_flag, carry_flag, done, illegal_op} !== 38'd0) begin
            fails++; $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h pc=%h opc=%h z=%b c=%b done=%b ill=%b want all 0",
                mem_req, mem_we, mem_addr, mem_wdata, pc_out, opcode_out, zero_flag, carry_flag, done, illegal_op);
        end
        reset_n = 1'b1; #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 5'd0) begin
            fails++; $display("FAIL reset_first_fetch: got req=%b addr=%0d want req=1 addr=0", mem_req, mem_addr);
        end
        @(negedge clock);
        tests++; if (pc_out !== 5'd1 || mem_req !== 1'b0) begin
            fails++; $display("FAIL reset_decode: got pc=%0d req=%b want pc=1 req=0", pc_out, mem_req);
        end
    endtask

    task automatic test_program();
        clear_prog();
        prog[0] = enc(LDI, 2'd1, 5'd5);
        prog[1] = enc(LDI, 2'd2, 5'd3);
        prog[2] = enc(ADD, 2'd1, 5'd2);
        prog[3] = enc(HALT, 2'd0, 5'd0);
        start();
        step(11);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL prog_done_early: got done=%b at cycle 11 want 0", done); end
        step(1);
        tests++; if (done !== 1'b1 || zero_flag !== 1'b0 || carry_flag !== 1'b0 || pc_out !== 5'd4 || opcode_out !== 5'd31) begin
            fails++; $display("FAIL prog_cycle12: got done=%b z=%b c=%b pc=%0d opc=%0d want 1 0 0 4 31", done, zero_flag, carry_flag, pc_out, opcode_out);
        end
        step(3);
        tests++; if (done !== 1'b1 || mem_req !== 1'b0 || pc_out !== 5'd4) begin
            fails++; $display("FAIL halt_absorbing: got done=%b req=%b pc=%0d want 1 0 4", done, mem_req, pc_out);
        end
        prog[3] = enc(ST, 2'd1, 5'd30);
        prog[4] = enc(HALT, 2'd0, 5'd0);
        start();
        run_to_done(40, n);
        tests++; if (n !== 16 || wmem[30] !== 16'd8) begin
            fails++; $display("FAIL prog_store_r1: got cycles=%0d mem30=%h want 16 0008", n, wmem[30]);
        end
    endtask

    task automatic test_alu();
        clear_prog();
        prog[0] = enc(LDI, 2'd1, 5'd0);
        prog[1] = enc(LDI, 2'd2, 5'd1);
        prog[2] = enc(SUB, 2'd1, 5'd2);
        prog[3] = enc(ST, 2'd1, 5'd30);
        prog[4] = enc(HALT, 2'd0, 5'd0);
        start();
        run_to_done(40, n);
        tests++; if (wmem[30] !== 16'hFFFF || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
            fails++; $display("FAIL sub_borrow: got r1=%h c=%b z=%b want ffff 1 0", wmem[30], carry_flag, zero_flag);
        end
        prog[3] = enc(ADD, 2'd1, 5'd2);
        prog[4] = enc(ST, 2'd1, 5'd30);
        prog[5] = enc(HALT, 2'd0, 5'd0);
        start();
        run_to_done(40, n);
        tests++; if (wmem[30] !== 16'h0000 || carry_flag !== 1'b1 || zero_flag !== 1'b1) begin
            fails++; $display("FAIL add_carry: got r1=%h c=%b z=%b want 0000 1 1", wmem[30], carry_flag, zero_flag);
        end
        clear_prog();
        prog[0] = enc(LDI, 2'd0, 5'd6);
        prog[1] = enc(LDI, 2'd1, 5'd3);
        prog[2] = enc(SUB, 2'd1, 5'd0);
        prog[3] = enc(AND_, 2'd0, 5'd1);
        prog[4] = enc(ST, 2'd0, 5'd28);
        prog[5] = enc(OR_, 2'd0, 5'd1);
        prog[6] = enc(ST, 2'd0, 5'd27);
        prog[7] = enc(SUB, 2'd1, 5'd1);
        prog[8] = enc(ST, 2'd1, 5'd26);
        prog[9] = enc(HALT, 2'd0, 5'd0);
        start();
        step(9);
        tests++; if (carry_flag !== 1'b1) begin fails++; $display("FAIL sub_sets_carry: got c=%b want 1", carry_flag); end
        step(3);
        tests++; if (carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
            fails++; $display("FAIL and_clears_carry: got c=%b z=%b want 0 0", carry_flag, zero_flag);
        end
        run_to_done(60, n);
        tests++; if (wmem[28] !== 16'h0004 || wmem[27] !== 16'hFFFD || wmem[26] !== 16'h0000 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            fails++; $display("FAIL logic_ops: got and=%h or=%h sub_self=%h z=%b c=%b want 0004 fffd 0000 1 0",
                wmem[28], wmem[27], wmem[26], zero_flag, carry_flag);
        end
    endtask

    task automatic test_mem_wait();
        clear_prog();
        prog[0]  = enc(LD, 2'd0, 5'd20);
        prog[1]  = enc(ST, 2'd0, 5'd21);
        prog[2]  = enc(HALT, 2'd0, 5'd0);
        prog[20] = 16'hBEEF;
        start();
        step(3);
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++; if (mem_req !== 1'b1 || mem_addr !== 5'd20 || mem_we !== 1'b0) begin
                fails++; $display("FAIL ld_wait_stable%0d: got req=%b addr=%0d we=%b want 1 20 0", k, mem_req, mem_addr, mem_we);
            end
            if (k == 3) mem_ready = 1'b1;
            @(negedge clock);
        end
        step(3);
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'd21 || mem_wdata !== 16'hBEEF) begin
                fails++; $display("FAIL st_drive%0d: got req=%b we=%b addr=%0d wd=%h want 1 1 21 beef", k, mem_req, mem_we, mem_addr, mem_wdata);
            end
            if (k == 1) mem_ready = 1'b1;
            @(negedge clock);
        end
        run_to_done(20, n);
        tests++; if (done !== 1'b1 || wmem[21] !== 16'hBEEF) begin
            fails++; $display("FAIL ld_st_result: got done=%b mem21=%h want 1 beef", done, wmem[21]);
        end
    endtask

    task automatic test_wrap();
        clear_prog();
        prog[0]  = enc(JMP, 2'd0, 5'd31);
        prog[31] = enc(JZ, 2'd3, 5'd0);
        start();
        step(3);
        tests++; if (pc_out !== 5'd31 || mem_addr !== 5'd31 || mem_req !== 1'b1) begin
            fails++; $display("FAIL jmp_31: got pc=%0d addr=%0d req=%b want 31 31 1", pc_out, mem_addr, mem_req);
        end
        step(1);
        tests++; if (pc_out !== 5'd0) begin fails++; $display("FAIL pc_wrap: got pc=%0d want 0", pc_out); end
        step(1);
        tests++; if (opcode_out !== 5'd9) begin fails++; $display("FAIL jz_decode: got opc=%0d want 9", opcode_out); end
        step(1);
        tests++; if (pc_out !== 5'd0 || mem_addr !== 5'd0 || mem_req !== 1'b1) begin
            fails++; $display("FAIL jz_to_0: got pc=%0d addr=%0d req=%b want 0 0 1", pc_out, mem_addr, mem_req);
        end
        clear_prog();
        prog[0]  = enc(LDI, 2'd3, 5'd1);
        prog[1]  = enc(JMP, 2'd0, 5'd31);
        prog[31] = enc(JZ, 2'd3, 5'd4);
        prog[4]  = enc(HALT, 2'd0, 5'd0);
        start();
        step(9);
        tests++; if (pc_out !== 5'd0) begin fails++; $display("FAIL jz_not_taken: got pc=%0d want 0", pc_out); end
        clear_prog();
        prog[0]  = enc(JMP, 2'd0, 5'd31);
        prog[31] = enc(JZ, 2'd2, 5'd4);
        prog[4]  = enc(HALT, 2'd0, 5'd0);
        start();
        run_to_done(40, n);
        tests++; if (n !== 9 || pc_out !== 5'd5) begin
            fails++; $display("FAIL jz_taken: got cycles=%0d pc=%0d want 9 5", n, pc_out);
        end
    endtask

    task automatic test_illegal();
        clear_prog();
        prog[0] = enc(5'd12, 2'd0, 5'd0);
        prog[1] = enc(LDI, 2'd1, 5'd9);
        prog[2] = enc(ST, 2'd1, 5'd25);
        prog[3] = enc(HALT, 2'd0, 5'd0);
        start();
        step(3);
`ifdef MC_CPU_ILLEGAL_TRAP_EN
        tests++; if (done !== 1'b1 || illegal_op !== 1'b1 || mem_req !== 1'b0 || pc_out !== 5'd1) begin
            fails++; $display("FAIL illegal_trap: got done=%b ill=%b req=%b pc=%0d want 1 1 0 1", done, illegal_op, mem_req, pc_out);
        end
        step(2);
        tests++; if (done !== 1'b1 || illegal_op !== 1'b1) begin
            fails++; $display("FAIL illegal_hold: got done=%b ill=%b want 1 1", done, illegal_op);
        end
`else
        tests++; if (done !== 1'b0 || illegal_op !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 5'd1) begin
            fails++; $display("FAIL illegal_nop: got done=%b ill=%b req=%b addr=%0d want 0 0 1 1", done, illegal_op, mem_req, mem_addr);
        end
        run_to_done(40, n);
        tests++; if (n !== 10 || wmem[25] !== 16'd9 || illegal_op !== 1'b0) begin
            fails++; $display("FAIL illegal_continue: got cycles=%0d mem25=%h ill=%b want 10 0009 0", n, wmem[25], illegal_op);
        end
`endif
    endtask

    task automatic test_reset_mid();
        clear_prog();
        prog[0]  = enc(LDI, 2'd1, 5'd17);
        prog[1]  = enc(LD, 2'd2, 5'd20);
        prog[2]  = enc(HALT, 2'd0, 5'd0);
        prog[20] = 16'h1234;
        start();
        step(6);
        mem_ready = 1'b0;
        step(1);
        tests++; if (mem_req !== 1'b1 || mem_addr !== 5'd20) begin
            fails++; $display("FAIL mid_wait: got req=%b addr=%0d want 1 20", mem_req, mem_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b0 || pc_out !== 5'd0 || opcode_out !== 5'd0 || mem_addr !== 5'd0) begin
            fails++; $display("FAIL mid_reset_async: got req=%b pc=%0d opc=%0d addr=%0d want 0 0 0 0", mem_req, pc_out, opcode_out, mem_addr);
        end
        clear_prog();
        prog[0] = enc(ST, 2'd1, 5'd24);
        prog[1] = enc(ST, 2'd2, 5'd23);
        prog[2] = enc(HALT, 2'd0, 5'd0);
        mem_ready = 1'b1;
        @(negedge clock);
        reset_n = 1'b1; #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 5'd0) begin
            fails++; $display("FAIL mid_refetch: got req=%b addr=%0d want 1 0", mem_req, mem_addr);
        end
        run_to_done(40, n);
        tests++; if (n !== 11 || wmem[24] !== 16'h0000 || wmem[23] !== 16'h0000) begin
            fails++; $display("FAIL mid_regs_cleared: got cycles=%0d r1=%h r2=%h want 11 0000 0000", n, wmem[24], wmem[23]);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        clear_prog();
        test_reset();
        test_program();
        test_alu();
        test_mem_wait();
        test_wrap();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
